// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder
// Latches one spike count per channel (3 channels) and replays it as an
// evenly spaced spike train over 'accumulate_interval' timesteps, using a
// Bresenham-style accumulator per channel. Timesteps leave through a
// valid/ready handshake; a stalled timestep holds all state and outputs.
module spike_rate_encoder #(
    parameter int TIMER_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TIMER_WIDTH-1:0] accumulate_interval,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TIMER_WIDTH-1:0] count_0,
    input  logic [TIMER_WIDTH-1:0] count_1,
    input  logic [TIMER_WIDTH-1:0] count_2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   spike_0,
    output logic                   spike_1,
    output logic                   spike_2,
    output logic                   frame_last
);

    localparam int NCH = 3;
    localparam logic [TIMER_WIDTH-1:0] ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMER_WIDTH-1:0] ZERO = {TIMER_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    logic [TIMER_WIDTH-1:0] step_q;
    logic [TIMER_WIDTH-1:0] interval_q;
    logic [TIMER_WIDTH-1:0] cnt_q [NCH];
    logic [TIMER_WIDTH-1:0] acc_q [NCH];

    logic [TIMER_WIDTH-1:0] count_in_s [NCH];
    logic [TIMER_WIDTH:0]   sum_s      [NCH];
    logic [TIMER_WIDTH-1:0] acc_d      [NCH];
    logic [NCH-1:0]         spike_s;
    logic                   run_s;
    logic                   last_s;
    logic                   xfer_s;

    // A channel can never be asked for more spikes than there are timesteps.
    function automatic logic [TIMER_WIDTH-1:0] clamp_count(
        input logic [TIMER_WIDTH-1:0] cnt,
        input logic [TIMER_WIDTH-1:0] lim
    );
        return (cnt > lim) ? lim : cnt;
    endfunction

    assign count_in_s[0] = count_0;
    assign count_in_s[1] = count_1;
    assign count_in_s[2] = count_2;

    assign run_s  = (state_q == RUN);
    assign last_s = run_s && (step_q == (interval_q - ONE));
    assign xfer_s = run_s && out_ready;

    // Per-channel accumulator step: spike when the running sum reaches the interval.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_s[i]   = {1'b0, acc_q[i]} + {1'b0, cnt_q[i]};
            spike_s[i] = run_s && (sum_s[i] >= {1'b0, interval_q});
            // The true result always fits in TIMER_WIDTH bits, so modular math is exact.
            if (spike_s[i]) begin
                acc_d[i] = acc_q[i] + cnt_q[i] - interval_q;
            end else begin
                acc_d[i] = acc_q[i] + cnt_q[i];
            end
        end
    end

    assign in_ready   = !run_s;
    assign out_valid  = run_s;
    assign spike_0    = spike_s[0];
    assign spike_1    = spike_s[1];
    assign spike_2    = spike_s[2];
    assign frame_last = last_s;

    // Frame FSM: accept a frame in IDLE, advance one timestep per transfer in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= ZERO;
            interval_q <= ZERO;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= ZERO;
                acc_q[i] <= ZERO;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        interval_q <= accumulate_interval;
                        step_q     <= ZERO;
                        for (int i = 0; i < NCH; i++) begin
                            cnt_q[i] <= clamp_count(count_in_s[i], accumulate_interval);
                            acc_q[i] <= ZERO;
                        end
                        // A zero-length frame has nothing to emit and is dropped.
                        state_q <= (accumulate_interval != ZERO) ? RUN : IDLE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (xfer_s) begin
                        step_q <= step_q + ONE;
                        for (int i = 0; i < NCH; i++) begin
                            acc_q[i] <= acc_d[i];
                        end
                        state_q <= last_s ? IDLE : RUN;
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder. Inputs are driven and outputs
// sampled on the falling edge. The reference model predicts the spike at
// step s of a frame as floor((s+1)*c/I) > floor(s*c/I), with c clamped to I.
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] accumulate_interval;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] count_0, count_1, count_2;
    logic       out_valid;
    logic       out_ready;
    logic       spike_0, spike_1, spike_2;
    logic       frame_last;

    int n_pass  = 0;
    int n_total = 0;

    spike_rate_encoder #(.TIMER_WIDTH(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .accumulate_interval (accumulate_interval),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .count_0             (count_0),
        .count_1             (count_1),
        .count_2             (count_2),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .spike_0             (spike_0),
        .spike_1             (spike_1),
        .spike_2             (spike_2),
        .frame_last          (frame_last)
    );

    always #5 clk = ~clk;

    // Bundle of the observable outputs: {out_valid, spike_0, spike_1, spike_2, frame_last}
    function automatic logic [4:0] obs_vec();
        return {out_valid, spike_0, spike_1, spike_2, frame_last};
    endfunction

    // Reference: spike at step s when the ideal cumulative count floor(s*c/I) steps up.
    function automatic bit model_spike(int s, int c, int iv);
        int cc;
        cc = (c > iv) ? iv : c;
        return (((s + 1) * cc) / iv) > ((s * cc) / iv);
    endfunction

    function automatic logic [4:0] model_vec(int s, int c0, int c1, int c2, int iv);
        return {1'b1, model_spike(s, c0, iv), model_spike(s, c1, iv),
                model_spike(s, c2, iv), (s == iv - 1)};
    endfunction

    // Offer one frame at the current falling edge; returns at the first RUN timestep.
    task automatic start_frame(input int iv, input int c0, input int c1, input int c2);
        accumulate_interval = 5'(iv);
        count_0  = 5'(c0);
        count_1  = 5'(c1);
        count_2  = 5'(c2);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({in_ready, obs_vec()} !== 6'b1_00000)
            $display("FAIL reset_state: got %b expected %b", {in_ready, obs_vec()}, 6'b1_00000);
        else n_pass++;
        // Abandon a frame at step 3 of 8.
        out_ready = 1'b1;
        start_frame(8, 3, 5, 7);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_mid_run: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
        else n_pass++;
        // The next frame must start from clean accumulators.
        start_frame(8, 3, 5, 7);
        for (int s = 0; s < 8; s++) begin
            n_total++;
            if (obs_vec() !== model_vec(s, 3, 5, 7, 8))
                $display("FAIL reset_new_frame step %0d: got %b expected %b", s, obs_vec(), model_vec(s, 3, 5, 7, 8));
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_even_spacing();
        logic [3:0] e0, e1, e2, el;
        logic [4:0] exp_v;
        e0 = 4'b1000; e1 = 4'b1010; e2 = 4'b1111; el = 4'b1000;
        out_ready = 1'b1;
        start_frame(4, 1, 2, 4);
        for (int s = 0; s < 4; s++) begin
            exp_v = {1'b1, e0[s], e1[s], e2[s], el[s]};
            n_total++;
            if (obs_vec() !== exp_v)
                $display("FAIL even_spacing step %0d: got %b expected %b", s, obs_vec(), exp_v);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL even_spacing_end: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_clamp_zero();
        logic [4:0] exp_v;
        out_ready = 1'b1;
        start_frame(5, 0, 9, 5);
        for (int s = 0; s < 5; s++) begin
            exp_v = {1'b1, 1'b0, 1'b1, 1'b1, (s == 4)};
            n_total++;
            if (obs_vec() !== exp_v)
                $display("FAIL clamp_zero step %0d: got %b expected %b", s, obs_vec(), exp_v);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int c1, c2, t, k;
        logic [4:0] prev_v;
        logic prev_rdy;
        c1 = $urandom_range(0, 6);
        c2 = $urandom_range(0, 6);
        start_frame(6, 3, c1, c2);
        t = 0; k = 0; prev_rdy = 1'b1; prev_v = 5'b00000;
        while (t < 6 && k < 40) begin
            out_ready = (k % 3 == 0);
            // Mid-frame input changes must be ignored.
            count_0 = 5'($urandom_range(0, 31));
            accumulate_interval = 5'($urandom_range(0, 31));
            n_total++;
            if (!prev_rdy && obs_vec() !== prev_v)
                $display("FAIL backpressure_hold cycle %0d: got %b expected %b", k, obs_vec(), prev_v);
            else if (obs_vec() !== model_vec(t, 3, c1, c2, 6))
                $display("FAIL backpressure step %0d: got %b expected %b", t, obs_vec(), model_vec(t, 3, c1, c2, 6));
            else n_pass++;
            prev_v = obs_vec();
            prev_rdy = out_ready;
            if (out_ready) t++;
            k++;
            @(negedge clk);
        end
        n_total++;
        if (t != 6 || {in_ready, out_valid} !== 2'b10)
            $display("FAIL backpressure_end: got transfers %0d in_ready/out_valid %b expected 6 and 10", t, {in_ready, out_valid});
        else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        int r0, r1, r2, s;
        logic [4:0] exp_v;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        r0 = 0; r1 = 0; r2 = 0;
        for (int k = 0; k < 12; k++) begin
            s = (k % 4) - 1;
            exp_v = (k % 4 == 0) ? 5'b00000 : model_vec(s, r0, r1, r2, 3);
            n_total++;
            if ({in_ready, obs_vec()} !== {(k % 4 == 0), exp_v})
                $display("FAIL back_to_back cycle %0d: got %b expected %b", k, {in_ready, obs_vec()}, {(k % 4 == 0), exp_v});
            else n_pass++;
            if (k % 4 == 0) begin
                accumulate_interval = 5'd3;
                r0 = $urandom_range(0, 5); r1 = $urandom_range(0, 5); r2 = $urandom_range(0, 5);
            end else begin
                accumulate_interval = 5'($urandom_range(1, 31));
            end
            count_0 = 5'(r0); count_1 = 5'(r1); count_2 = 5'(r2);
            if (k % 4 != 0) begin
                count_0 = 5'($urandom_range(0, 31));
                count_1 = 5'($urandom_range(0, 31));
                count_2 = 5'($urandom_range(0, 31));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_degenerate();
        logic [4:0] exp_v;
        out_ready = 1'b1;
        start_frame(0, 4, 4, 4);
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({in_ready, obs_vec()} !== 6'b1_00000)
                $display("FAIL zero_interval cycle %0d: got %b expected %b", k, {in_ready, obs_vec()}, 6'b1_00000);
            else n_pass++;
            @(negedge clk);
        end
        start_frame(31, 31, 31, 31);
        for (int s = 0; s < 31; s++) begin
            exp_v = {4'b1111, (s == 30)};
            n_total++;
            if (obs_vec() !== exp_v)
                $display("FAIL interval_31 step %0d: got %b expected %b", s, obs_vec(), exp_v);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL interval_31_end: got in_ready/out_valid %b expected 10", {in_ready, out_valid});
        else n_pass++;
    endtask

    task automatic test_random();
        int iv, c0, c1, c2, t, k, n0, n1, n2;
        for (int f = 0; f < 6; f++) begin
            iv = $urandom_range(1, 31);
            c0 = $urandom_range(0, 31); c1 = $urandom_range(0, 31); c2 = $urandom_range(0, 31);
            start_frame(iv, c0, c1, c2);
            t = 0; k = 0; n0 = 0; n1 = 0; n2 = 0;
            while (t < iv && k < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                n_total++;
                if (obs_vec() !== model_vec(t, c0, c1, c2, iv))
                    $display("FAIL random frame %0d step %0d: got %b expected %b", f, t, obs_vec(), model_vec(t, c0, c1, c2, iv));
                else n_pass++;
                if (out_ready) begin
                    n0 += int'(spike_0); n1 += int'(spike_1); n2 += int'(spike_2);
                    t++;
                end
                k++;
                @(negedge clk);
            end
            n_total++;
            if (t != iv || n0 != ((c0 > iv) ? iv : c0) || n1 != ((c1 > iv) ? iv : c1)
                || n2 != ((c2 > iv) ? iv : c2) || in_ready !== 1'b1)
                $display("FAIL random_totals frame %0d: got steps %0d spikes %0d/%0d/%0d in_ready %b expected %0d %0d/%0d/%0d 1",
                         f, t, n0, n1, n2, in_ready, iv, (c0 > iv) ? iv : c0, (c1 > iv) ? iv : c1, (c2 > iv) ? iv : c2);
            else n_pass++;
        end
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        accumulate_interval = 5'd0;
        count_0 = 5'd0; count_1 = 5'd0; count_2 = 5'd0;
        @(negedge clk);
        test_reset();
        test_even_spacing();
        test_clamp_zero();
        test_backpressure();
        test_back_to_back();
        test_degenerate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
